// File: rtl/ifetch_pkg.sv
// Shared constants and types for the b-risc instruction-fetch stage.
package ifetch_pkg;

   localparam int ADDR_W     = 32;
   localparam int INSTR_W    = 32;
   localparam int IMEM_REQ_W = ADDR_W;
   localparam int DROP_W     = 8;

   localparam logic [INSTR_W-1:0] INSTR_NOP     = 32'h0000_0013;
   localparam logic [ADDR_W-1:0]  PC_STEP       = ADDR_W'(4);
   localparam logic [ADDR_W-1:0]  PC_ALIGN_MASK = ~ADDR_W'(3);

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   localparam int ENTRY_W = $bits(fetch_entry_t);

   // Fetch targets are always word aligned; the low two bits are dropped.
   function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] pc);
      return pc & PC_ALIGN_MASK;
   endfunction

endpackage

// File: rtl/ifetch_if.sv
// Instruction-memory request/response bus between ifetch (master) and imem (slave).
interface ifetch_if;
   import ifetch_pkg::*;

   logic                  req;
   logic [IMEM_REQ_W-1:0] addr;
   logic                  ready;
   logic                  valid;
   logic [INSTR_W-1:0]    data;

   modport master (output req, addr, input ready, valid, data);
   modport slave  (input req, addr, output ready, valid, data);
endinterface

// File: rtl/ifetch_fifo.sv
// Small response FIFO: push/pop/clear, occupancy count and head output.
// A simultaneous push and pop on a full FIFO is legal and keeps the count.
module ifetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             push,
   input  logic             pop,
   input  logic             clear,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] head,
   output logic [CNT_W-1:0] count,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign head  = mem[rd_ptr];
   assign empty = (count == '0);

   // Storage array: written on push, never reset (pointers define validity).
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wdata;
   end

   // Pointer and occupancy bookkeeping; clear empties the FIFO in one cycle.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= next_ptr(wr_ptr);
         if (pop)  rd_ptr <= next_ptr(rd_ptr);
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

endmodule

// File: rtl/ifetch.sv
// b-risc instruction-fetch stage: owns the fetch PC, issues imem requests under a
// credit limit (requests in flight + buffered words <= BUF_DEPTH), buffers responses
// and hands one instruction per cycle to id, with NOP bubbles when nothing is valid.
// Optional feature macro: IFETCH_MISALIGN_CHK_EN adds the o_misalign pulse output.
module ifetch
   import ifetch_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter int                BUF_DEPTH = 2
) (
   input  logic               clk,
   input  logic               clr,
   input  logic               stall,
   input  logic               i_redirect,
   input  logic [ADDR_W-1:0]  i_redirect_pc,
   ifetch_if.master           imem,
   output logic [ADDR_W-1:0]  o_pc,
   output logic [INSTR_W-1:0] o_instr,
   output logic               o_valid
`ifdef IFETCH_MISALIGN_CHK_EN
   ,
   output logic               o_misalign
`endif
);

   localparam int CNT_W = $clog2(BUF_DEPTH + 1) + 1;
   localparam logic [CNT_W:0] CREDIT = (CNT_W + 1)'(BUF_DEPTH);

   logic [ADDR_W-1:0] fpc;
   logic [ADDR_W-1:0] pc_tag;
   logic [CNT_W-1:0]  inflight;
   logic [CNT_W-1:0]  fifo_count;
   logic [DROP_W-1:0] drop;
   logic              fifo_empty;
   logic              accept;
   logic              live;
   logic              push;
   logic              pop;
   logic [ADDR_W-1:0] target;
   fetch_entry_t      head_e;
   fetch_entry_t      resp_e;

   assign target   = align_pc(i_redirect_pc);
   assign imem.req = !clr && !i_redirect
                     && (({1'b0, inflight} + {1'b0, fifo_count}) < CREDIT);
   assign imem.addr = fpc;
   assign accept   = imem.req && imem.ready;
   // A response is live only when no stale responses are still owed.
   assign live     = imem.valid && (drop == '0);
   assign resp_e   = '{pc: pc_tag, instr: imem.data};
   // Buffer the response unless it can go straight into the output register.
   assign push     = live && !i_redirect && (stall || !fifo_empty);
   assign pop      = !stall && !i_redirect && !fifo_empty;

   ifetch_fifo #(
      .DEPTH (BUF_DEPTH),
      .WIDTH (ENTRY_W),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk   (clk),
      .clr   (clr),
      .push  (push),
      .pop   (pop),
      .clear (i_redirect),
      .wdata (resp_e),
      .head  (head_e),
      .count (fifo_count),
      .empty (fifo_empty)
   );

   // Fetch PC, response PC tag, in-flight and stale-response accounting.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         fpc      <= RESET_PC;
         pc_tag   <= RESET_PC;
         inflight <= '0;
         drop     <= '0;
      end else if (i_redirect) begin
         // Everything still owed becomes stale; a response landing now is discarded.
         drop     <= drop + DROP_W'(inflight) - DROP_W'(imem.valid);
         inflight <= '0;
         fpc      <= target;
         pc_tag   <= target;
      end else begin
         if (accept) fpc <= fpc + PC_STEP;
         if (live)   pc_tag <= pc_tag + PC_STEP;
         inflight <= inflight + CNT_W'(accept) - CNT_W'(live);
         if (imem.valid && !live) drop <= drop - DROP_W'(1);
      end
   end

   // Output register to id: FIFO head first, then bypass, otherwise a NOP bubble.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         o_pc    <= RESET_PC;
         o_instr <= INSTR_NOP;
         o_valid <= 1'b0;
      end else if (i_redirect) begin
         o_instr <= INSTR_NOP;
         o_valid <= 1'b0;
      end else if (!stall) begin
         if (!fifo_empty) begin
            o_pc    <= head_e.pc;
            o_instr <= head_e.instr;
            o_valid <= 1'b1;
         end else if (live) begin
            o_pc    <= pc_tag;
            o_instr <= imem.data;
            o_valid <= 1'b1;
         end else begin
            o_instr <= INSTR_NOP;
            o_valid <= 1'b0;
         end
      end
   end

`ifdef IFETCH_MISALIGN_CHK_EN
   // One-cycle flag for a redirect target with non-zero low bits.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) o_misalign <= 1'b0;
      else     o_misalign <= i_redirect && (i_redirect_pc[1:0] != 2'b00);
   end
`endif

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: a cycle table for stream/stall/redirect-in-stall,
// plus hand-written sequences for redirect with requests in flight, misaligned
// redirect and ready toggling with a 3-cycle memory.
module tb_ifetch;
   import ifetch_pkg::*;

   logic              clk = 1'b0;
   logic              clr;
   logic              stall;
   logic              redirect;
   logic [31:0]       rpc;
   logic [31:0]       o_pc;
   logic [31:0]       o_instr;
   logic              o_valid;
`ifdef IFETCH_MISALIGN_CHK_EN
   logic              o_misalign;
`endif

   ifetch_if imem ();

   ifetch dut (
      .clk           (clk),
      .clr           (clr),
      .stall         (stall),
      .i_redirect    (redirect),
      .i_redirect_pc (rpc),
      .imem          (imem.master),
      .o_pc          (o_pc),
      .o_instr       (o_instr),
      .o_valid       (o_valid)
`ifdef IFETCH_MISALIGN_CHK_EN
      ,
      .o_misalign    (o_misalign)
`endif
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // memory model: fixed-latency pipe of accepted requests
   logic        pv [4];
   logic [31:0] pa [4];
   int          lat = 1;
   logic        toggle = 1'b0;
   logic        last_req;
   int          outstanding = 0;
   int          max_out = 0;

   typedef struct {
      logic        stall;
      logic        redir;
      logic [31:0] rpc;
      logic        req;
      logic        valid;
      logic [31:0] pc;
   } vec_t;

   vec_t vt [20];

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return 32'hA500_0000 | a;
   endfunction

   function automatic vec_t mk(input logic s, input logic r, input logic [31:0] p,
                               input logic q, input logic v, input logic [31:0] pc);
      vec_t x;
      x.stall = s; x.redir = r; x.rpc = p; x.req = q; x.valid = v; x.pc = pc;
      return x;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      logic        acc;
      logic [31:0] a;
      @(negedge clk);
      last_req = imem.req;
      acc = imem.req && imem.ready;
      a   = imem.addr;
      if (acc) begin
         outstanding++;
         if (outstanding > max_out) max_out = outstanding;
      end
      if (dut.u_fifo.push && !dut.u_fifo.pop && int'(dut.u_fifo.count) == 2) begin
         errors++;
         $display("FAIL fifo_overflow: push into full fifo at time %0t", $time);
      end
      @(posedge clk);
      #1;
      if (imem.valid) outstanding--;
      for (int i = 3; i > 0; i--) begin
         pv[i] = pv[i-1];
         pa[i] = pa[i-1];
      end
      pv[0] = acc;
      pa[0] = a;
      imem.valid = pv[lat-1];
      imem.data  = pv[lat-1] ? instr_of(pa[lat-1]) : 32'h0;
      if (toggle) imem.ready = !imem.ready;
   endtask

   task automatic do_reset(input int l);
      clr = 1'b1;
      stall = 1'b0; redirect = 1'b0; rpc = 32'h0; toggle = 1'b0;
      imem.ready = 1'b1; imem.valid = 1'b0; imem.data = 32'h0;
      for (int i = 0; i < 4; i++) begin
         pv[i] = 1'b0;
         pa[i] = 32'h0;
      end
      lat = l; outstanding = 0; max_out = 0;
      #1;
      chk("rst_valid", 32'(o_valid), 32'h0);
      chk("rst_pc", o_pc, 32'h0);
      chk("rst_instr", o_instr, INSTR_NOP);
      chk("rst_req", 32'(imem.req), 32'h0);
`ifdef IFETCH_MISALIGN_CHK_EN
      chk("rst_misalign", 32'(o_misalign), 32'h0);
`endif
      repeat (2) @(posedge clk);
      #1;
      clr = 1'b0;
      #1;
      chk("rel_req", 32'(imem.req), 32'h1);
   endtask

   task automatic collect(input int n, input logic [31:0] base, input int budget,
                          input string tag);
      int got = 0;
      int cyc = 0;
      while (got < n && cyc < budget) begin
         if (o_valid) begin
            chk($sformatf("%s_pc%0d", tag, got), o_pc, base + 32'(4 * got));
            chk($sformatf("%s_instr%0d", tag, got), o_instr, instr_of(base + 32'(4 * got)));
            got++;
         end
         if (got < n) begin
            tick();
            cyc++;
         end
      end
      if (got < n) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got %0d words expected %0d", tag, got, n);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      clr = 1'b0; stall = 1'b0; redirect = 1'b0; rpc = 32'h0;
      imem.ready = 1'b1; imem.valid = 1'b0; imem.data = 32'h0;
      #2;

      // stall, redir, rpc | req, valid, pc  (latency 1, ready 1)
      vt[0]  = mk(0, 0, 0, 1, 0, 32'h0);
      vt[1]  = mk(0, 0, 0, 1, 1, 32'h0);
      vt[2]  = mk(0, 0, 0, 1, 1, 32'h4);
      vt[3]  = mk(0, 0, 0, 1, 1, 32'h8);
      vt[4]  = mk(0, 0, 0, 1, 1, 32'hC);
      vt[5]  = mk(1, 0, 0, 1, 1, 32'hC);
      vt[6]  = mk(1, 0, 0, 0, 1, 32'hC);
      vt[7]  = mk(1, 0, 0, 0, 1, 32'hC);
      vt[8]  = mk(1, 0, 0, 0, 1, 32'hC);
      vt[9]  = mk(0, 0, 0, 0, 1, 32'h10);
      vt[10] = mk(0, 0, 0, 1, 1, 32'h14);
      vt[11] = mk(0, 0, 0, 1, 1, 32'h18);
      vt[12] = mk(0, 0, 0, 1, 1, 32'h1C);
      vt[13] = mk(1, 0, 0, 1, 1, 32'h1C);
      vt[14] = mk(1, 1, 32'h200, 0, 0, 32'h0);
      vt[15] = mk(1, 0, 0, 1, 0, 32'h0);
      vt[16] = mk(1, 0, 0, 1, 0, 32'h0);
      vt[17] = mk(0, 0, 0, 0, 1, 32'h200);
      vt[18] = mk(0, 0, 0, 1, 1, 32'h204);
      vt[19] = mk(0, 0, 0, 1, 1, 32'h208);

      do_reset(1);
      for (int i = 0; i < 20; i++) begin
         stall = vt[i].stall;
         redirect = vt[i].redir;
         rpc = vt[i].rpc;
         tick();
         chk($sformatf("v%0d_req", i), 32'(last_req), 32'(vt[i].req));
         chk($sformatf("v%0d_valid", i), 32'(o_valid), 32'(vt[i].valid));
         chk($sformatf("v%0d_instr", i), o_instr,
             vt[i].valid ? instr_of(vt[i].pc) : INSTR_NOP);
         if (vt[i].valid) chk($sformatf("v%0d_pc", i), o_pc, vt[i].pc);
      end
      stall = 1'b0; redirect = 1'b0;

      // redirect with two requests in flight, latency 3 (also a mid-stream reset)
      do_reset(3);
      tick();
      tick();
      chk("rd_outstanding", 32'(outstanding), 32'h2);
      redirect = 1'b1; rpc = 32'h100;
      tick();
      redirect = 1'b0;
      chk("rd_req_blocked", 32'(last_req), 32'h0);
      chk("rd_bubble_valid", 32'(o_valid), 32'h0);
      chk("rd_bubble_instr", o_instr, INSTR_NOP);
      n = 0;
      while (!o_valid && n < 20) begin
         tick();
         n++;
      end
      chk("rd_first_latency", 32'(n), 32'h4);
      collect(3, 32'h100, 20, "rd");

      // misaligned redirect target is forced to a word boundary
      redirect = 1'b1; rpc = 32'h302;
      tick();
      redirect = 1'b0;
      chk("al_addr", imem.addr, 32'h300);
`ifdef IFETCH_MISALIGN_CHK_EN
      chk("al_misalign_pulse", 32'(o_misalign), 32'h1);
`endif
      tick();
`ifdef IFETCH_MISALIGN_CHK_EN
      chk("al_misalign_clear", 32'(o_misalign), 32'h0);
`endif
      collect(2, 32'h300, 30, "al");

      // ready toggling 1/0 with latency 3: in order, never more than 2 outstanding
      do_reset(3);
      toggle = 1'b1;
      collect(6, 32'h0, 80, "rt");
      toggle = 1'b0;
      chk("rt_max_inflight_le2", 32'(max_out <= 2), 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
